decinfo_queue: RTL

DECINFO_QUEUE -- requirements
Module: decinfo_queue

---
 rtl/decinfo_queue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/decinfo_queue.sv
// decinfo_queue: in-order queue between decode and rename.
// Accepts up to two decoded instructions per cycle, offers one head per cycle,
// and serialises instructions flagged need_serialize around an idle backend.
// Optional feature: define DECINFO_QUEUE_BYPASS_EN to let an instruction entering
// an empty queue be offered to rename in the same cycle.

package decinfo_pkg;

  typedef struct packed {
    logic        need_serialize;
    logic [3:0]  fu_type;
    logic [4:0]  rd;
    logic [31:0] pc;
  } decinfo_t;

endpackage

module decinfo_queue
  import decinfo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             i_enq_vld,
  input  decinfo_t [1:0]         i_enq_inst,
  output logic                   o_can_enq,
  output logic                   o_deq_vld,
  input  logic                   i_deq_rdy,
  output decinfo_t               o_deq_inst,
  input  logic                   i_backend_idle,
  input  logic                   i_flush,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SER_PRE  = 2'd1,
    SER_POST = 2'd2
  } ser_state_t;

  decinfo_t         mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  ser_state_t       state;
  ser_state_t       state_nxt;

  decinfo_t         head_inst;
  logic             queue_vld;
  logic             bypass_vld;
  logic             bypass_take;
  logic             pop;
  logic             enq_fire;
  logic             wr0;
  logic             wr1;
  logic [PTR_W-1:0] wr1_addr;
  logic [1:0]       n_wr;

  assign head_inst = mem[head];
  assign o_count   = count;

  // Space for two is judged from registered occupancy only.
  assign o_can_enq = (count <= CNT_W'(DEPTH - 2));

  // Serialisation FSM: decides whether the stored head may be offered.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_nxt = state;
    queue_vld = 1'b0;
    unique case (state)
      RUN: begin
        queue_vld = (count != '0) && !head_inst.need_serialize;
        if ((count != '0) && head_inst.need_serialize) state_nxt = SER_PRE;
      end
      SER_PRE: begin
        queue_vld = i_backend_idle;
        if (i_backend_idle && i_deq_rdy) state_nxt = SER_POST;
      end
      SER_POST: begin
        if (i_backend_idle) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (i_flush) state_nxt = RUN;
  end

`ifdef DECINFO_QUEUE_BYPASS_EN
  // Empty queue: the incoming oldest slot is offered directly to rename.
  assign bypass_vld = (count == '0) && (state == RUN) && !i_flush &&
                      i_enq_vld[0] && !i_enq_inst[0].need_serialize;
  assign o_deq_inst = bypass_vld ? i_enq_inst[0] : head_inst;
`else
  // Without bypass the output comes from storage only.
  assign bypass_vld = 1'b0;
  assign o_deq_inst = head_inst;
`endif

  assign o_deq_vld   = queue_vld | bypass_vld;
  assign bypass_take = bypass_vld && i_deq_rdy;
  assign pop         = queue_vld && i_deq_rdy && !i_flush;

  // A bypassed slot0 is consumed by rename and never stored; slot1 then
  // lands where slot0 would have gone.
  assign enq_fire = o_can_enq && !i_flush && !rst;
  assign wr0      = enq_fire && i_enq_vld[0] && !bypass_take;
  assign wr1      = enq_fire && i_enq_vld[1];
  assign wr1_addr = wr0 ? tail + PTR_W'(1) : tail;
  assign n_wr     = {1'b0, wr0} + {1'b0, wr1};

  // Pointer, occupancy and FSM state registers; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= RUN;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= RUN;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(n_wr);
      count <= count + CNT_W'(n_wr) - CNT_W'(pop);
      state <= state_nxt;
    end
  end

  // Entry storage writes for the accepted slots.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy alone says which entries are live.
    if (wr0) mem[tail] <= i_enq_inst[0];
    if (wr1) mem[wr1_addr] <= i_enq_inst[1];
  end

endmodule
